// File: rtl/adc_sample_reader.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_reader
// Purpose  : Host-side controller for an ADC0804-style 8-bit converter. On a
//            fixed sample tick it pulses WR to start a conversion, waits for
//            the end-of-conversion INTR, drives CS/RD, latches the byte and
//            emits a one-cycle sample_valid strobe.
// Ports    : clk          - system clock
//            reset        - synchronous active-high reset
//            enable       - 1 = run periodic conversions
//            adc_data     - ADC parallel data bus
//            adc_intr_n   - ADC end-of-conversion, active low, asynchronous
//            adc_cs_n     - ADC chip select, active low
//            adc_rd_n     - ADC read strobe, active low
//            adc_wr_n     - ADC start-conversion strobe, active low
//            sample       - last captured byte, held until the next capture
//            sample_valid - one-cycle pulse when sample updates
//            timeout_err  - sticky: INTR never arrived in time
//            overrun      - sticky: a tick arrived while a conversion was busy
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_reader #(
  parameter int SAMPLE_DIV     = 100_000,
  parameter int WR_LOW_CYCLES  = 10,
  parameter int RD_CYCLES      = 20,
  parameter int TIMEOUT_CYCLES = 20_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] adc_data,
  input  logic       adc_intr_n,
  output logic       adc_cs_n,
  output logic       adc_rd_n,
  output logic       adc_wr_n,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       timeout_err,
  output logic       overrun
);

  localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  // One phase counter serves the WR pulse, the INTR timeout and the RD pulse.
  localparam int PH_MAX = (TIMEOUT_CYCLES > WR_LOW_CYCLES) ?
                          ((TIMEOUT_CYCLES > RD_CYCLES) ? TIMEOUT_CYCLES : RD_CYCLES) :
                          ((WR_LOW_CYCLES > RD_CYCLES) ? WR_LOW_CYCLES : RD_CYCLES);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0]  c_wr_last   = PH_W'(WR_LOW_CYCLES - 1);
  localparam logic [PH_W-1:0]  c_rd_last   = PH_W'(RD_CYCLES - 1);
  localparam logic [PH_W-1:0]  c_to_last   = PH_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_INTR = 3'd2,
    ST_READ      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   tick_cnt_q;
  logic [CNT_W-1:0]   tick_cnt_d;
  logic [PH_W-1:0]    ph_q;
  logic               intr_meta_q;
  logic               intr_s_q;
  logic               cs_n_q;
  logic               rd_n_q;
  logic               wr_n_q;
  logic [7:0]         sample_q;
  logic               valid_q;
  logic               timeout_q;
  logic               overrun_q;
  logic               w_tick;

  // Sample-rate divider; held at zero while disabled so the first tick after
  // enabling comes a full period later.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (!enable || (tick_cnt_q == c_tick_last)) begin
      tick_cnt_d = '0;
    end
  end

  assign w_tick = enable && (tick_cnt_q == c_tick_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      intr_meta_q <= 1'b1;
      intr_s_q    <= 1'b1;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      intr_meta_q <= adc_intr_n;
      intr_s_q    <= intr_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ph_q      <= '0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      sample_q  <= 8'h00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Ticks are not queued: a tick while busy is simply lost and flagged.
      if (w_tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (w_tick) begin
            state_q <= ST_START;
            ph_q    <= '0;
            cs_n_q  <= 1'b0;
            wr_n_q  <= 1'b0;
          end
        end
        ST_START: begin
          if (ph_q == c_wr_last) begin
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            ph_q    <= '0;
            state_q <= ST_WAIT_INTR;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_WAIT_INTR: begin
          // INTR wins over the timeout if both happen in the same cycle.
          if (!intr_s_q) begin
            state_q <= ST_READ;
            ph_q    <= '0;
            cs_n_q  <= 1'b0;
            rd_n_q  <= 1'b0;
          end else if (ph_q == c_to_last) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_READ: begin
          if (ph_q == c_rd_last) begin
            sample_q <= adc_data;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_rd_n     = rd_n_q;
  assign adc_wr_n     = wr_n_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign timeout_err  = timeout_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_reader
// Purpose  : Self-checking bench for adc_sample_reader. An ADC behavioural
//            model answers each conversion from a plan queue; expected bytes
//            and flag states go into a scoreboard popped on sample_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sample_reader;

  localparam int DIV = 200;
  localparam int WRL = 10;
  localparam int RDL = 20;
  localparam int TMO = 500;

  // Conversion categories, chosen so the busy time is clearly classified:
  // short finishes before the next tick, long spans exactly one tick,
  // timeout spans two ticks before the FSM gives up.
  localparam int CAT_SHORT   = 0;
  localparam int CAT_OVERRUN = 1;
  localparam int CAT_TIMEOUT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] adc_data;
  logic       adc_intr_n;
  logic       adc_cs_n;
  logic       adc_rd_n;
  logic       adc_wr_n;
  logic [7:0] sample;
  logic       sample_valid;
  logic       timeout_err;
  logic       overrun;

  typedef struct {
    int         delay;
    logic [7:0] data;
    int         cat;
  } plan_t;

  typedef struct {
    logic [7:0] data;
    logic       ovr;
    logic       to;
  } exp_t;

  plan_t plans[$];
  exp_t  sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int wr_falls = 0;
  int viol     = 0;
  bit prev_fall_ok = 1'b0;
  bit exp_ovr = 1'b0;
  bit exp_to  = 1'b0;

  adc_sample_reader #(
    .SAMPLE_DIV    (DIV),
    .WR_LOW_CYCLES (WRL),
    .RD_CYCLES     (RDL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .adc_data    (adc_data),
    .adc_intr_n  (adc_intr_n),
    .adc_cs_n    (adc_cs_n),
    .adc_rd_n    (adc_rd_n),
    .adc_wr_n    (adc_wr_n),
    .sample      (sample),
    .sample_valid(sample_valid),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic plan_t mk(input int d, input logic [7:0] b, input int c);
    plan_t p;
    p.delay = d;
    p.data  = b;
    p.cat   = c;
    return p;
  endfunction

  function automatic plan_t rnd_short();
    return mk($urandom_range(140, 1), 8'($urandom), CAT_SHORT);
  endfunction

  // ADC behavioural model plus strobe-shape and spacing observer.
  initial begin : adc_model
    int    m_state;
    int    m_cnt;
    int    wr_run;
    int    rd_run;
    int    last_fall;
    int    exp_spacing;
    logic  prev_wr;
    logic  prev_rd;
    plan_t m_plan;
    exp_t  e;
    m_state = 0; m_cnt = 0; wr_run = 0; rd_run = 0; last_fall = 0;
    exp_spacing = DIV; prev_wr = 1'b1; prev_rd = 1'b1;
    m_plan = mk(0, 8'h00, CAT_SHORT);
    adc_intr_n = 1'b1;
    adc_data   = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        adc_intr_n   = 1'b1;
        m_state      = 0;
        wr_run       = 0;
        rd_run       = 0;
        prev_fall_ok = 1'b0;
      end else begin
        if (!adc_wr_n && !adc_rd_n) viol++;
        if ((!adc_wr_n || !adc_rd_n) && adc_cs_n) viol++;
        case (m_state)
          1: begin
            m_cnt++;
            if (m_cnt >= m_plan.delay) begin
              adc_intr_n = 1'b0;
              adc_data   = m_plan.data;
              e.data = m_plan.data;
              e.ovr  = exp_ovr;
              e.to   = exp_to;
              sb.push_back(e);
              m_state = 2;
            end
          end
          2: begin
            if (!adc_rd_n) begin
              adc_intr_n = 1'b1;
              m_state    = 0;
            end
          end
          3: begin
            m_cnt++;
            if (timeout_err) begin
              chk("timeout_latency", m_cnt, TMO);
              m_state = 0;
            end else if (m_cnt > 2 * TMO) begin
              chk("timeout_seen", 0, 1);
              m_state = 0;
            end
          end
          default: ;
        endcase
        if (prev_wr && !adc_wr_n) begin
          wr_falls++;
          if (prev_fall_ok) chk("wr_spacing", cyc - last_fall, exp_spacing);
          last_fall    = cyc;
          prev_fall_ok = 1'b1;
        end
        if (!adc_wr_n) wr_run++;
        if (!prev_wr && adc_wr_n) begin
          chk("wr_low_width", wr_run, WRL);
          wr_run = 0;
          m_plan = (plans.size() > 0) ? plans.pop_front() : rnd_short();
          m_cnt  = 0;
          case (m_plan.cat)
            CAT_OVERRUN: begin exp_spacing = 2 * DIV; exp_ovr = 1'b1; m_state = 1; end
            CAT_TIMEOUT: begin exp_spacing = 3 * DIV; exp_ovr = 1'b1; exp_to = 1'b1; m_state = 3; end
            default:     begin exp_spacing = DIV; m_state = 1; end
          endcase
        end
        if (!adc_rd_n) rd_run++;
        if (!prev_rd && adc_rd_n) begin
          chk("rd_low_width", rd_run, RDL);
          rd_run = 0;
        end
      end
      prev_wr = adc_wr_n;
      prev_rd = adc_rd_n;
    end
  end

  // Output monitor: pops the scoreboard on every sample_valid.
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && sample_valid) begin
        valid_cnt++;
        if (prev_valid) viol++;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sample_byte", int'(sample), int'(e.data));
          chk("overrun_at_valid", int'(overrun), int'(e.ovr));
          chk("timeout_at_valid", int'(timeout_err), int'(e.to));
        end
      end
      prev_valid = sample_valid;
    end
  end

  task automatic wait_valid(input int target, input int budget, input string name);
    int n = 0;
    while (valid_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(valid_cnt >= target), 1);
  endtask

  task automatic wait_rd_low(input int budget, input string name);
    int n = 0;
    while (adc_rd_n && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(!adc_rd_n), 1);
  endtask

  initial begin : main
    int snap;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(adc_cs_n), 1);
    chk("rst_rd_n", int'(adc_rd_n), 1);
    chk("rst_wr_n", int'(adc_wr_n), 1);
    chk("rst_sample", int'(sample), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_timeout", int'(timeout_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;

    // Nominal, fixed byte sequence, random shorts, one overrun, more shorts.
    plans.push_back(mk(50, 8'hA5, CAT_SHORT));
    plans.push_back(mk(50, 8'h00, CAT_SHORT));
    plans.push_back(mk(50, 8'hFF, CAT_SHORT));
    plans.push_back(mk(50, 8'h3C, CAT_SHORT));
    for (int i = 0; i < 4; i++) plans.push_back(rnd_short());
    plans.push_back(mk(190, 8'($urandom), CAT_OVERRUN));
    for (int i = 0; i < 2; i++) plans.push_back(rnd_short());
    @(negedge clk);
    enable = 1'b1;
    wait_valid(11, 6000, "nominal_done");
    chk("overrun_sticky", int'(overrun), 1);
    chk("no_timeout_yet", int'(timeout_err), 0);

    // Timeout (no valid), then a normal conversion with timeout_err set.
    plans.push_back(mk(0, 8'h00, CAT_TIMEOUT));
    plans.push_back(rnd_short());
    wait_valid(12, 2000, "after_timeout_done");
    chk("timeout_sticky", int'(timeout_err), 1);

    // Drop enable during READ: this conversion still completes.
    plans.push_back(rnd_short());
    wait_rd_low(1000, "enable_drop_reach_read");
    enable       = 1'b0;
    prev_fall_ok = 1'b0;
    wait_valid(13, 100, "enable_drop_valid");
    snap = wr_falls;
    repeat (1000) @(negedge clk);
    chk("no_wr_while_disabled", wr_falls, snap);
    chk("valid_after_disable", valid_cnt, 13);

    // Reset in the middle of READ.
    plans.push_back(mk(100, 8'($urandom), CAT_SHORT));
    enable = 1'b1;
    wait_rd_low(1000, "reset_reach_read");
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cs_n", int'(adc_cs_n), 1);
    chk("midrst_rd_n", int'(adc_rd_n), 1);
    chk("midrst_wr_n", int'(adc_wr_n), 1);
    chk("midrst_sample", int'(sample), 0);
    chk("midrst_timeout", int'(timeout_err), 0);
    chk("midrst_overrun", int'(overrun), 0);
    sb.delete();
    plans.delete();
    exp_ovr = 1'b0;
    exp_to  = 1'b0;
    enable  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    chk("valid_total", valid_cnt, 13);
    chk("strobe_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
